dcache_sa: RTL

// Parametrised N-way set-associative, write-through, no-write-allocate data cache between the CPU load/store port and the read/write buses.

---
 rtl/dcache_sa.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/dcache_sa.sv
// dcache_sa: N-way set-associative write-through, no-write-allocate D-cache.
// Ports: cpu_clk/cpu_rst; CPU side data_ren/data_addr/data_valid/data_rdata,
//   data_wen/data_wdata/data_wresp; write bus cpu_wen/cpu_waddr/cpu_wdata,
//   dev_wrdy; read bus cpu_ren/cpu_raddr, dev_rrdy, dev_rvalid/dev_rdata.
module dcache_sa #(
  parameter int         WAYS      = 2,
  parameter int         SETS      = 64,
  parameter int         BLK_WORDS = 4,
  parameter logic [3:0] UC_TOP    = 4'hF
) (
  input  logic                   cpu_clk,
  input  logic                   cpu_rst,
  input  logic [3:0]             data_ren,
  input  logic [31:0]            data_addr,
  output logic                   data_valid,
  output logic [31:0]            data_rdata,
  input  logic [3:0]             data_wen,
  input  logic [31:0]            data_wdata,
  output logic                   data_wresp,
  input  logic                   dev_wrdy,
  output logic [3:0]             cpu_wen,
  output logic [31:0]            cpu_waddr,
  output logic [31:0]            cpu_wdata,
  input  logic                   dev_rrdy,
  output logic [3:0]             cpu_ren,
  output logic [31:0]            cpu_raddr,
  input  logic                   dev_rvalid,
  input  logic [32*BLK_WORDS-1:0] dev_rdata
);
  localparam int OB  = $clog2(BLK_WORDS * 4);
  localparam int IB  = $clog2(SETS);
  localparam int TB  = 32 - OB - IB;
  localparam int WSB = $clog2(BLK_WORDS);
  localparam int WB  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {R_IDLE, R_REQ, R_WAIT, R_DONE} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;

  r_state_t r_state, r_next;
  w_state_t w_state, w_next;

  logic [SETS-1:0] valid_q [WAYS];
  logic [TB-1:0]   tag_q   [WAYS][SETS];
  logic [31:0]     data_q  [WAYS][SETS][BLK_WORDS];
  logic [WB-1:0]   rr_q    [SETS];

  logic [IB-1:0]  a_idx;
  logic [TB-1:0]  a_tag;
  logic [WSB-1:0] a_wsel;
  logic           a_cached;
  logic [IB-1:0]  f_idx;
  logic [TB-1:0]  f_tag;

  logic          hit;
  logic [WB-1:0] hit_way;
  logic [WB-1:0] vic_way;
  logic          r_uc;
  logic [31:0]   uc_data;
  logic          fill;
  logic          w_issue;
  logic          w_done;

  assign a_idx    = data_addr[OB+IB-1:OB];
  assign a_tag    = data_addr[31:OB+IB];
  assign a_wsel   = data_addr[OB-1:2];
  assign a_cached = data_addr[31:28] != UC_TOP;

  // Refill targets the latched request address, not the live CPU address.
  assign f_idx = cpu_raddr[OB+IB-1:OB];
  assign f_tag = cpu_raddr[31:OB+IB];

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][a_idx] && tag_q[w][a_idx] == a_tag) begin
        hit     = a_cached;
        hit_way = WB'(w);
      end
    end
  end

  // Lowest invalid way wins; otherwise the set's round-robin pointer.
  always_comb begin
    vic_way = rr_q[f_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid_q[w][f_idx]) vic_way = WB'(w);
    end
  end

  assign fill    = r_state == R_WAIT && dev_rvalid && !r_uc;
  assign w_issue = w_state != W_RESP && w_next == W_RESP;
  assign w_done  = w_state == W_RESP && cpu_wen == 4'h0 && dev_wrdy;

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
    end else begin
      r_state <= r_next;
      w_state <= w_next;
    end
  end

  // A store in flight (or arriving) blocks new read launches.
  always_comb begin
    r_next = r_state;
    unique case (r_state)
      R_IDLE: if (|data_ren && !hit && w_state == W_IDLE && !(|data_wen))
                r_next = R_REQ;
      R_REQ:  if (dev_rrdy) r_next = R_WAIT;
      R_WAIT: if (dev_rvalid) r_next = r_uc ? R_DONE : R_IDLE;
      R_DONE: r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    w_next = w_state;
    unique case (w_state)
      W_IDLE: if (|data_wen && !data_wresp)
                w_next = dev_wrdy ? W_RESP : W_WAIT;
      W_WAIT: if (dev_wrdy) w_next = W_RESP;
      W_RESP: if (cpu_wen == 4'h0 && dev_wrdy) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    data_valid = 1'b0;
    data_rdata = '0;
    if (r_state == R_DONE) begin
      data_valid = 1'b1;
      data_rdata = uc_data;
    end else if (r_state == R_IDLE && |data_ren && hit) begin
      data_valid = 1'b1;
      data_rdata = data_q[hit_way][a_idx][a_wsel];
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      cpu_ren    <= '0;
      cpu_raddr  <= '0;
      r_uc       <= 1'b0;
      uc_data    <= '0;
      cpu_wen    <= '0;
      cpu_waddr  <= '0;
      cpu_wdata  <= '0;
      data_wresp <= 1'b0;
    end else begin
      cpu_ren    <= '0;
      cpu_wen    <= '0;
      data_wresp <= w_done;
      if (r_state == R_REQ && dev_rrdy) begin
        cpu_ren   <= a_cached ? 4'hF : data_ren;
        cpu_raddr <= a_cached ? {data_addr[31:OB], {OB{1'b0}}}
                              : data_addr;
        r_uc      <= !a_cached;
      end
      if (r_state == R_WAIT && dev_rvalid && r_uc)
        uc_data <= dev_rdata[31:0];
      if (w_issue) begin
        cpu_wen   <= data_wen;
        cpu_waddr <= data_addr;
        cpu_wdata <= data_wdata;
      end
    end
  end

  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      for (int w = 0; w < WAYS; w++) valid_q[w] <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else if (fill) begin
      valid_q[vic_way][f_idx] <= 1'b1;
      if (WAYS > 1) rr_q[f_idx] <= rr_q[f_idx] + WB'(1);
    end
  end

  // Line storage needs no reset; valid bits gate every use.
  always_ff @(posedge cpu_clk) begin
    if (fill) begin
      tag_q[vic_way][f_idx] <= f_tag;
      for (int k = 0; k < BLK_WORDS; k++)
        data_q[vic_way][f_idx][k] <= dev_rdata[32*k +: 32];
    end
    if (w_issue && hit) begin
      for (int b = 0; b < 4; b++)
        if (data_wen[b])
          data_q[hit_way][a_idx][a_wsel][8*b +: 8] <= data_wdata[8*b +: 8];
    end
  end

endmodule
